// File: rtl/pkt_rr_scheduler.sv
// Round-robin scheduler sharing one packet output register among N_SRC
// per-source FIFOs, with a pndng/pop handshake on the output side.
module pkt_rr_scheduler #(
    parameter int PCKG_SZ   = 40,
    parameter int DEEP_FIFO = 8,
    parameter int N_SRC     = 4,
    localparam int IDW      = $clog2(N_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         push,
    input  logic [N_SRC*PCKG_SZ-1:0] data_in,
    output logic [N_SRC-1:0]         full,
    output logic [N_SRC-1:0]         overflow,
    output logic [PCKG_SZ-1:0]       data_out,
    output logic                     pndng_out,
    output logic [IDW-1:0]           grant_id,
    input  logic                     pop
);

    localparam int AW = $clog2(DEEP_FIFO);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_e;

    state_e state_q, state_d;

    logic [PCKG_SZ-1:0] mem_q [N_SRC][DEEP_FIFO];

    logic [AW-1:0] wr_ptr_q [N_SRC];
    logic [AW-1:0] wr_ptr_d [N_SRC];
    logic [AW-1:0] rd_ptr_q [N_SRC];
    logic [AW-1:0] rd_ptr_d [N_SRC];
    logic [CW-1:0] cnt_q    [N_SRC];
    logic [CW-1:0] cnt_d    [N_SRC];

    logic [N_SRC-1:0] ovf_q, ovf_d;
    logic [N_SRC-1:0] nonempty;
    logic [N_SRC-1:0] full_w;
    logic [N_SRC-1:0] wr_en;
    logic [N_SRC-1:0] deq;

    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] winner;
    logic           found;
    logic           load;

    logic [PCKG_SZ-1:0] data_q, data_d;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            full_w[i]   = (cnt_q[i] == CW'(DEEP_FIFO));
        end
    end

    // Scan farthest candidate first so the nearest one after last_q wins.
    always_comb begin
        logic [IDW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = IDW'((int'(last_q) + k) % N_SRC);
            if (nonempty[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        load    = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pop) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (load) begin
            data_d  = mem_q[winner][rd_ptr_q[winner]];
            grant_d = winner;
            last_d  = winner;
        end
    end

    // A full FIFO still accepts a push when it is drained on the same edge.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            deq[i]      = load && (winner == IDW'(i));
            wr_en[i]    = push[i] && (!full_w[i] || deq[i]);
            ovf_d[i]    = ovf_q[i] | (push[i] & full_w[i] & ~deq[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_en[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(deq[i]);
            cnt_d[i]    = cnt_q[i] + CW'(wr_en[i]) - CW'(deq[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= data_in[i*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDW'(N_SRC - 1);
            ovf_q   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign full      = full_w;
    assign overflow  = ovf_q;
    assign data_out  = data_q;
    assign grant_id  = grant_q;
    assign pndng_out = (state_q == S_HOLD);

endmodule
